// File: rtl/param_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : param_shift_unit
//  Description : Step-button driven shift/rotate unit of configurable width.
//                Synchronises and debounces a raw push-button. Each accepted
//                press runs one of eight datapath operations, updates a
//                shift-out bit and advances a wrapping step counter.
//  Revision    : 1.0  initial release
// ============================================================================
module param_shift_unit #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_W         = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               step,
  input  logic [2:0]         mode,
  input  logic               serialIn,
  input  logic [WIDTH-1:0]   parIn,
  output logic [WIDTH-1:0]   outShift,
  output logic               serialOut,
  output logic [COUNT_W-1:0] stepCount
);

  // Debounce counter is wide enough to reach DEBOUNCE_CYCLES-1 (at least 1 bit)
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_LOAD  = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_ROL   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_CLEAR = 3'b111;

  logic             s1;
  logic             s2;
  logic             db_level;
  logic [CNT_W-1:0] db_cnt;
  logic             exec_op;

  // An operation fires on the edge where the accepted level rises 0->1
  assign exec_op = s2 && !db_level && (db_cnt == CNT_LAST);

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= step;
      s2 <= s1;
    end
  end

  // Debouncer: accept a new level only after it has been stable long enough
  always_ff @(posedge clock) begin
    if (reset) begin
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else if (s2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_LAST) begin
      db_level <= s2;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  // Datapath, shift-out bit and step counter update only on an execute edge
  always_ff @(posedge clock) begin
    if (reset) begin
      outShift  <= '0;
      serialOut <= 1'b0;
      stepCount <= '0;
    end else if (exec_op) begin
      stepCount <= stepCount + COUNT_W'(1);
      case (mode)
        MODE_HOLD: begin
          outShift <= outShift;
        end
        MODE_SHR: begin
          outShift  <= {serialIn, outShift[WIDTH-1:1]};
          serialOut <= outShift[0];
        end
        MODE_SHL: begin
          outShift  <= {outShift[WIDTH-2:0], serialIn};
          serialOut <= outShift[WIDTH-1];
        end
        MODE_LOAD: begin
          outShift <= parIn;
        end
        MODE_ROR: begin
          outShift  <= {outShift[0], outShift[WIDTH-1:1]};
          serialOut <= outShift[0];
        end
        MODE_ROL: begin
          outShift  <= {outShift[WIDTH-2:0], outShift[WIDTH-1]};
          serialOut <= outShift[WIDTH-1];
        end
        MODE_ASR: begin
          outShift  <= {outShift[WIDTH-1], outShift[WIDTH-1:1]};
          serialOut <= outShift[0];
        end
        MODE_CLEAR: begin
          outShift  <= '0;
          serialOut <= 1'b0;
        end
        default: begin
          outShift <= outShift;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_shift_unit
//  Description : Directed self-checking bench for param_shift_unit
//                (WIDTH=8, DEBOUNCE_CYCLES=4, COUNT_W=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_shift_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic       step;
  logic [2:0] mode;
  logic       serialIn;
  logic [7:0] parIn;
  logic [7:0] outShift;
  logic       serialOut;
  logic [7:0] stepCount;

  int n_checks = 0;
  int n_passed = 0;

  param_shift_unit #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .COUNT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .step(step),
    .mode(mode),
    .serialIn(serialIn),
    .parIn(parIn),
    .outShift(outShift),
    .serialOut(serialOut),
    .stepCount(stepCount)
  );

  always #5 clock = ~clock;

  // One clock edge, then settle so inputs change and outputs are read away from the edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Clean press: 8 cycles high (op fires on the 6th edge), 8 cycles low to release
  task automatic press(input logic [2:0] m, input logic sin, input logic [7:0] par);
    mode     = m;
    serialIn = sin;
    parIn    = par;
    step     = 1'b1;
    tick(8);
    step     = 1'b0;
    mode     = 3'b000;
    serialIn = ~sin;
    parIn    = ~par;
    tick(8);
  endtask

  initial begin
    reset = 1'b1; step = 1'b0; mode = 3'b000; serialIn = 1'b0; parIn = 8'h00;
    tick(2);
    reset = 1'b0;
    tick(1);
    check_eq("rst_out",   outShift,  8'h00);
    check_eq("rst_sout",  serialOut, 1'b0);
    check_eq("rst_count", stepCount, 8'h00);

    // Test 1: LOAD with latency check and no repeat while held
    mode = 3'b011; parIn = 8'hA5; step = 1'b1;
    tick(5);                       // edges E0..E0+4
    check_eq("lat_out_before",   outShift,  8'h00);
    check_eq("lat_count_before", stepCount, 8'h00);
    tick(1);                       // edge E0+5
    check_eq("lat_out_at",   outShift,  8'hA5);
    check_eq("lat_count_at", stepCount, 8'h01);
    parIn = 8'h11; mode = 3'b111;  // ignored: not an execute edge
    tick(6);
    check_eq("held_out",   outShift,  8'hA5);
    check_eq("held_count", stepCount, 8'h01);
    step = 1'b0;
    tick(8);

    // Test 2: shifts from A5
    press(3'b001, 1'b1, 8'h00);
    check_eq("shr_out",  outShift,  8'hD2);
    check_eq("shr_sout", serialOut, 1'b1);
    press(3'b011, 1'b0, 8'hA5);
    press(3'b010, 1'b0, 8'h00);
    check_eq("shl_out",  outShift,  8'h4A);
    check_eq("shl_sout", serialOut, 1'b1);

    // Test 3: rotates, arithmetic shift, clear
    press(3'b011, 1'b0, 8'hA5);
    press(3'b100, 1'b0, 8'h00);
    check_eq("ror_out",  outShift,  8'hD2);
    check_eq("ror_sout", serialOut, 1'b1);
    press(3'b011, 1'b0, 8'hA5);
    press(3'b101, 1'b0, 8'h00);
    check_eq("rol_out",  outShift,  8'h4B);
    check_eq("rol_sout", serialOut, 1'b1);
    press(3'b011, 1'b0, 8'h85);
    press(3'b110, 1'b0, 8'h00);
    check_eq("asr_out",  outShift,  8'hC2);
    check_eq("asr_sout", serialOut, 1'b1);
    press(3'b111, 1'b1, 8'hFF);
    check_eq("clr_out",   outShift,  8'h00);
    check_eq("clr_sout",  serialOut, 1'b0);
    check_eq("clr_count", stepCount, 8'd11);

    // Hold and LOAD keep serialOut
    press(3'b011, 1'b0, 8'hA5);
    press(3'b001, 1'b0, 8'h00);
    check_eq("shr0_out",  outShift,  8'h52);
    check_eq("shr0_sout", serialOut, 1'b1);
    press(3'b000, 1'b0, 8'hFF);
    check_eq("hold_out",  outShift,  8'h52);
    check_eq("hold_sout", serialOut, 1'b1);
    press(3'b011, 1'b0, 8'h3C);
    check_eq("load_out",   outShift,  8'h3C);
    check_eq("load_sout",  serialOut, 1'b1);
    check_eq("load_count", stepCount, 8'd15);

    // Test 4: bounce gives no op, clean press gives exactly one
    mode = 3'b011; parIn = 8'h0F;
    step = 1'b1; tick(1);
    step = 1'b0; tick(1);
    step = 1'b1; tick(2);
    step = 1'b0; tick(10);
    check_eq("bounce_out",   outShift,  8'h3C);
    check_eq("bounce_count", stepCount, 8'd15);
    step = 1'b1; tick(10);
    step = 1'b0; tick(8);
    check_eq("clean_out",   outShift,  8'h0F);
    check_eq("clean_count", stepCount, 8'd16);

    // Test 5: reset in the middle of debounce, step kept high
    mode = 3'b011; parIn = 8'h99; step = 1'b1;
    tick(3);                       // edges E0..E0+2
    reset = 1'b1;
    tick(1);                       // edge E0+3 under reset
    check_eq("mid_rst_out",   outShift,  8'h00);
    check_eq("mid_rst_sout",  serialOut, 1'b0);
    check_eq("mid_rst_count", stepCount, 8'h00);
    reset = 1'b0;
    tick(5);
    check_eq("requal_before", stepCount, 8'h00);
    tick(1);
    check_eq("requal_out",   outShift,  8'h99);
    check_eq("requal_count", stepCount, 8'h01);
    step = 1'b0; tick(8);

    // Test 6: counter wraps after 256 hold presses
    for (int i = 0; i < 254; i++) press(3'b000, 1'b0, 8'h00);
    check_eq("cnt_ff", stepCount, 8'hFF);
    press(3'b000, 1'b0, 8'h00);
    check_eq("cnt_wrap", stepCount, 8'h00);
    press(3'b000, 1'b0, 8'h00);
    check_eq("cnt_after_wrap", stepCount, 8'h01);
    check_eq("wrap_out",       outShift,  8'h99);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
